// File: rtl/uart_cmd_sequencer_if.sv
// rtl/uart_cmd_sequencer_if.sv - receive-byte and config/run signal bundle for uart_cmd_sequencer
//
// Signals:
//   rx_data   [7:0]  received byte, valid while rx_valid=1
//   rx_valid         one-cycle strobe per received byte
//   cfg_we           one-cycle register bank write strobe
//   cfg_addr  [3:0]  register index for cfg_we
//   cfg_data  [15:0] register value for cfg_we
//   gen_run          pulse generator enable level
//   busy             frame partially received
//   frame_err        one-cycle strobe per rejected frame
//   err_cnt   [7:0]  saturating rejected-frame count
// Modports:
//   master  sequencer side (consumes rx, drives config/status)
//   slave   environment side (drives rx, observes config/status)

interface uart_cmd_sequencer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        gen_run;
  logic        busy;
  logic        frame_err;
  logic [7:0]  err_cnt;

  modport master (
    input  rx_data, rx_valid,
    output cfg_we, cfg_addr, cfg_data, gen_run, busy, frame_err, err_cnt
  );

  modport slave (
    output rx_data, rx_valid,
    input  cfg_we, cfg_addr, cfg_data, gen_run, busy, frame_err, err_cnt
  );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - frames UART bytes into register-bank / run-control write commands
//
// Frame: HDR, ADDR, DHI, DLO [, CHK]. ADDR[7:4] must be zero; ADDR[3:0] selects the register.
// Optional feature macro: CMD_CHECKSUM_EN (adds CHK byte = ADDR ^ DHI ^ DLO).
//
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous reset, active-high
//   bus   uart_cmd_sequencer_if.master
//           rx_data/rx_valid in; cfg_we/cfg_addr/cfg_data, gen_run, busy,
//           frame_err, err_cnt out

module uart_cmd_sequencer #(
  parameter logic [7:0] HDR_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CYC = 2000000,
  parameter logic [3:0] RUN_ADDR    = 4'hF
) (
  input logic                  clk,
  input logic                  rst,
  uart_cmd_sequencer_if.master bus
);

  localparam int            CW       = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DHI,
    DLO,
`ifdef CMD_CHECKSUM_EN
    CHK,
`endif
    COMMIT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] tmo_cnt, tmo_cnt_n;
  logic [3:0]    addr_q, addr_n;
  logic [7:0]    dhi_q, dhi_n;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]    dlo_q, dlo_n;
`endif

  logic [3:0]    cfg_addr_q;
  logic [15:0]   cfg_data_q;
  logic          gen_run_q;
  logic          frame_err_q;
  logic [7:0]    err_cnt_q;

  logic          commit_n;
  logic [15:0]   commit_data;
  logic          err_n;

  always_comb begin
    state_n     = state;
    tmo_cnt_n   = tmo_cnt + CW'(1);
    addr_n      = addr_q;
    dhi_n       = dhi_q;
`ifdef CMD_CHECKSUM_EN
    dlo_n       = dlo_q;
`endif
    commit_n    = 1'b0;
    commit_data = cfg_data_q;
    err_n       = 1'b0;

    if (state == IDLE || state == COMMIT) begin
      // COMMIT lasts one cycle and treats an incoming byte exactly like IDLE,
      // so a header arriving back-to-back starts the next frame.
      tmo_cnt_n = '0;
      state_n   = IDLE;
      if (bus.rx_valid && bus.rx_data == HDR_BYTE)
        state_n = ADDR;
    end else if (tmo_cnt == TMO_LAST) begin
      // Expiry has priority: a byte on this cycle is dropped, not re-examined.
      tmo_cnt_n = '0;
      state_n   = IDLE;
      err_n     = 1'b1;
    end else if (bus.rx_valid) begin
      tmo_cnt_n = '0;
      case (state)
        ADDR: begin
          if (bus.rx_data[7:4] == 4'h0) begin
            addr_n  = bus.rx_data[3:0];
            state_n = DHI;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
        DHI: begin
          dhi_n   = bus.rx_data;
          state_n = DLO;
        end
`ifdef CMD_CHECKSUM_EN
        DLO: begin
          dlo_n   = bus.rx_data;
          state_n = CHK;
        end
        CHK: begin
          if (bus.rx_data == ({4'h0, addr_q} ^ dhi_q ^ dlo_q)) begin
            commit_n    = 1'b1;
            commit_data = {dhi_q, dlo_q};
            state_n     = COMMIT;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
`else
        DLO: begin
          commit_n    = 1'b1;
          commit_data = {dhi_q, bus.rx_data};
          state_n     = COMMIT;
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      addr_q      <= '0;
      dhi_q       <= '0;
`ifdef CMD_CHECKSUM_EN
      dlo_q       <= '0;
`endif
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      gen_run_q   <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state       <= state_n;
      tmo_cnt     <= tmo_cnt_n;
      addr_q      <= addr_n;
      dhi_q       <= dhi_n;
`ifdef CMD_CHECKSUM_EN
      dlo_q       <= dlo_n;
`endif
      frame_err_q <= err_n;
      if (err_n && err_cnt_q != 8'hFF)
        err_cnt_q <= err_cnt_q + 8'd1;
      // Address/data are loaded on the edge entering COMMIT so they are
      // valid alongside cfg_we and hold until the next bank write.
      if (commit_n) begin
        if (addr_q == RUN_ADDR) begin
          gen_run_q <= commit_data[0];
        end else begin
          cfg_addr_q <= addr_q;
          cfg_data_q <= commit_data;
        end
      end
    end
  end

  assign bus.cfg_we    = (state == COMMIT) && (addr_q != RUN_ADDR);
  assign bus.cfg_addr  = cfg_addr_q;
  assign bus.cfg_data  = cfg_data_q;
  assign bus.gen_run   = gen_run_q;
  assign bus.busy      = (state != IDLE);
  assign bus.frame_err = frame_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule
